// File: rtl/alu_muldiv_seq_pkg.sv
// Shared types for the execute-stage ALU and its iterative multiply/divide unit.
package alu_muldiv_seq_pkg;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_control_t;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } muldiv_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } muldiv_state_t;

   // rs1 is treated as signed by MULH, MULHSU, DIV and REM
   function automatic logic op_a_signed(input muldiv_op_t op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   // rs2 is treated as signed by MULH, DIV and REM
   function automatic logic op_b_signed(input muldiv_op_t op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface alu_muldiv_seq_if
   import alu_muldiv_seq_pkg::*;
#(
   parameter int N = 32
);
   logic           in_valid;
   logic           in_ready;
   muldiv_op_t     op;
   logic [N-1:0]   a;
   logic [N-1:0]   b;
   logic           out_valid;
   logic           out_ready;
   logic [N-1:0]   result;
   logic           div_by_zero;
   logic           busy;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, result, div_by_zero, busy
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, result, div_by_zero, busy
   );
endinterface

// File: rtl/alu_muldiv_seq_step.sv
// One iteration of the multiply/divide datapath plus the shared ripple adder.

module adder_n #(
   parameter int N = 32
) (
   input  logic [N-1:0] i_x,
   input  logic [N-1:0] i_y,
   input  logic         i_cin,
   output logic [N-1:0] o_sum,
   output logic         o_cout
);
   assign {o_cout, o_sum} = {1'b0, i_x} + {1'b0, i_y} + {{N{1'b0}}, i_cin};
endmodule

module muldiv_step #(
   parameter int N = 32
) (
   input  logic           i_mode,     // 0: add-shift (multiply), 1: subtract-shift (divide)
   input  logic [2*N-1:0] i_acc,      // {hi, lo}: product/multiplier or remainder/quotient
   input  logic [N-1:0]   i_operand,  // multiplicand or divisor magnitude
   output logic [2*N-1:0] o_acc
);
   logic [2*N-1:0] w_shl;
   logic [N-1:0]   w_x;
   logic [N-1:0]   w_y;
   logic [N-1:0]   w_sum;
   logic           w_cout;
   logic           w_ge;

   assign w_shl = {i_acc[2*N-2:0], 1'b0};
   // Divide subtracts via x + ~y + 1; the remainder bit shifted out of the top
   // is the (N+1)th bit of the partial remainder and forces a successful trial.
   assign w_x   = i_mode ? w_shl[2*N-1:N] : i_acc[2*N-1:N];
   assign w_y   = i_mode ? ~i_operand : i_operand;
   assign w_ge  = i_acc[2*N-1] | w_cout;

   adder_n #(.N(N)) u_adder (
      .i_x    (w_x),
      .i_y    (w_y),
      .i_cin  (i_mode),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   // Select the next accumulator value for the chosen mode
   always_comb begin
      o_acc = '0;
      if (i_mode) begin
         o_acc = {(w_ge ? w_sum : w_shl[2*N-1:N]), w_shl[N-1:1], w_ge};
      end else if (i_acc[0]) begin
         o_acc = {w_cout, w_sum, i_acc[N-1:1]};
      end else begin
         o_acc = {1'b0, i_acc[2*N-1:1]};
      end
   end
endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative RV32M multiply/divide unit: one result bit per cycle, handshake in and out.
module alu_muldiv_seq
   import alu_muldiv_seq_pkg::*;
#(
   parameter int N = 32
) (
   input  logic              clk,
   input  logic              rst,
   alu_muldiv_seq_if.slave   bus
);
   localparam int CNT_W = $clog2(N) + 1;

   function automatic logic [N-1:0] neg_n(input logic [N-1:0] v);
      return ~v + {{(N-1){1'b0}}, 1'b1};
   endfunction

   function automatic logic [2*N-1:0] neg_2n(input logic [2*N-1:0] v);
      return ~v + {{(2*N-1){1'b0}}, 1'b1};
   endfunction

   muldiv_state_t  r_state, w_state_next;
   muldiv_op_t     r_op;
   logic [2*N-1:0] r_acc;
   logic [N-1:0]   r_operand;
   logic [CNT_W-1:0] r_cnt;
   logic           r_neg_a;
   logic           r_neg_res;
   logic [N-1:0]   r_result;
   logic           r_dbz;

   logic           w_accept, w_a_neg, w_b_neg, w_is_div, w_dbz, w_ovf, w_short;
   logic [N-1:0]   w_a_mag, w_b_mag, w_short_res;
   logic [2*N-1:0] w_step, w_prod;
   logic [N-1:0]   w_quot, w_rem, w_final;

   assign w_accept = bus.in_valid && (r_state == ST_IDLE);
   assign w_a_neg  = op_a_signed(bus.op) & bus.a[N-1];
   assign w_b_neg  = op_b_signed(bus.op) & bus.b[N-1];
   assign w_a_mag  = w_a_neg ? neg_n(bus.a) : bus.a;
   assign w_b_mag  = w_b_neg ? neg_n(bus.b) : bus.b;
   assign w_is_div = bus.op[2];
   assign w_dbz    = w_is_div && (bus.b == '0);
   assign w_ovf    = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                     (bus.a == {1'b1, {(N-1){1'b0}}}) && (bus.b == '1);
   assign w_short  = w_dbz || w_ovf;
   // REM/REMU have op[1] set; divide-by-zero returns a or all ones, overflow a or 0
   assign w_short_res = w_dbz ? (bus.op[1] ? bus.a : '1)
                              : ((bus.op == OP_DIV) ? bus.a : '0);

   muldiv_step #(.N(N)) u_step (
      .i_mode    (r_state == ST_DIV),
      .i_acc     (r_acc),
      .i_operand (r_operand),
      .o_acc     (w_step)
   );

   // Sign-correct the last iteration's output into the architectural result
   assign w_prod = r_neg_res ? neg_2n(w_step) : w_step;
   assign w_quot = r_neg_res ? neg_n(w_step[N-1:0]) : w_step[N-1:0];
   assign w_rem  = r_neg_a ? neg_n(w_step[2*N-1:N]) : w_step[2*N-1:N];
   always_comb begin
      w_final = '0;
      case (r_op)
         OP_MUL:                       w_final = w_prod[N-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod[2*N-1:N];
         OP_DIV, OP_DIVU:              w_final = w_quot;
         default:                      w_final = w_rem;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_state_next = w_short ? ST_DONE : (w_is_div ? ST_DIV : ST_MUL);
         ST_MUL,
         ST_DIV:  if (r_cnt == '0) w_state_next = ST_DONE;
         ST_DONE: if (bus.out_ready) w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      bus.in_ready    = (r_state == ST_IDLE);
      bus.out_valid   = (r_state == ST_DONE);
      bus.busy        = (r_state != ST_IDLE);
      bus.result      = r_result;
      bus.div_by_zero = r_dbz;
   end

   // Datapath: latch operands on accept, iterate, capture the final result
   always_ff @(posedge clk) begin
      if (rst) begin
         r_op      <= OP_MUL;
         r_acc     <= '0;
         r_operand <= '0;
         r_cnt     <= '0;
         r_neg_a   <= 1'b0;
         r_neg_res <= 1'b0;
         r_result  <= '0;
         r_dbz     <= 1'b0;
      end else if (w_accept) begin
         r_op      <= bus.op;
         r_acc     <= {{N{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
         r_operand <= w_is_div ? w_b_mag : w_a_mag;
         r_cnt     <= CNT_W'(N - 1);
         r_neg_a   <= w_a_neg;
         r_neg_res <= w_a_neg ^ w_b_neg;
         r_dbz     <= w_dbz;
         if (w_short) r_result <= w_short_res;
      end else if ((r_state == ST_MUL) || (r_state == ST_DIV)) begin
         r_acc <= w_step;
         r_cnt <= r_cnt - 1'b1;
         if (r_cnt == '0) r_result <= w_final;
      end
   end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed and randomized checks of the iterative multiply/divide unit.
module tb_alu_muldiv_seq;
   import alu_muldiv_seq_pkg::*;

   localparam int N = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_muldiv_seq_if #(.N(N)) bus ();

   alu_muldiv_seq #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: RV32M semantics computed with 64-bit arithmetic
   function automatic void ref_model(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output logic dbz, output int lat);
      longint sa, sb, ua, ub, p, q;
      logic   ovf;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      dbz = 1'b0;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      r = 32'd0;
      p = 0;
      q = 0;
      case (op)
         OP_MUL:    begin p = ua * ub; r = p[31:0];  end
         OP_MULH:   begin p = sa * sb; r = p[63:32]; end
         OP_MULHSU: begin p = sa * ub; r = p[63:32]; end
         OP_MULHU:  begin p = ua * ub; r = p[63:32]; end
         OP_DIV:  if (b == 0) begin r = 32'hFFFF_FFFF; dbz = 1'b1; end
                  else if (ovf) r = a;
                  else begin q = sa / sb; r = q[31:0]; end
         OP_DIVU: if (b == 0) begin r = 32'hFFFF_FFFF; dbz = 1'b1; end
                  else begin q = ua / ub; r = q[31:0]; end
         OP_REM:  if (b == 0) begin r = a; dbz = 1'b1; end
                  else if (ovf) r = 32'd0;
                  else begin q = sa % sb; r = q[31:0]; end
         default: if (b == 0) begin r = a; dbz = 1'b1; end
                  else begin q = ua % ub; r = q[31:0]; end
      endcase
      lat = (dbz || (ovf && (op == OP_DIV || op == OP_REM))) ? 1 : N + 1;
   endfunction

   // Present a request and return once it has been accepted (now in cycle 1)
   task automatic start_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
      int guard = 0;
      bus.in_valid = 1'b1;
      bus.op = op;
      bus.a  = a;
      bus.b  = b;
      while (bus.in_ready !== 1'b1 && guard < 200) begin
         @(posedge clk); #1; guard++;
      end
      if (guard >= 200) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.op = muldiv_op_t'($urandom_range(0, 7));
      bus.a  = $urandom;
      bus.b  = $urandom;
   endtask

   task automatic get_result(input string tag, input muldiv_op_t op, input logic [31:0] a,
                             input logic [31:0] b);
      logic [31:0] er;
      logic        ed;
      int          el;
      int          lat = 1;
      ref_model(op, a, b, er, ed, el);
      while (bus.out_valid !== 1'b1 && lat < 200) begin
         @(posedge clk); #1; lat++;
      end
      chk({tag, "_lat"}, 32'(lat), 32'(el));
      chk({tag, "_res"}, bus.result, er);
      chk({tag, "_dbz"}, {31'd0, bus.div_by_zero}, {31'd0, ed});
      $display("op=%0d a=%h b=%h result=%h dbz=%0b lat=%0d", op, a, b, bus.result, bus.div_by_zero, lat);
   endtask

   // Hold off the consumer for bp cycles, then take the result
   task automatic consume(input string tag, input int bp);
      logic [31:0] held;
      logic        held_dbz;
      held     = bus.result;
      held_dbz = bus.div_by_zero;
      for (int i = 0; i < bp; i++) begin
         @(posedge clk); #1;
         chk({tag, "_bp_valid"}, {31'd0, bus.out_valid}, 32'd1);
         chk({tag, "_bp_res"}, bus.result, held);
         chk({tag, "_bp_dbz"}, {31'd0, bus.div_by_zero}, {31'd0, held_dbz});
         chk({tag, "_bp_inrdy"}, {31'd0, bus.in_ready}, 32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk({tag, "_idle_inrdy"}, {31'd0, bus.in_ready}, 32'd1);
      chk({tag, "_idle_valid"}, {31'd0, bus.out_valid}, 32'd0);
   endtask

   task automatic run(input string tag, input muldiv_op_t op, input logic [31:0] a,
                      input logic [31:0] b, input int bp);
      start_op(op, a, b);
      get_result(tag, op, a, b);
      consume(tag, bp);
   endtask

   initial begin
      muldiv_op_t  rop;
      logic [31:0] ra, rb;

      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.op = OP_MUL;
      bus.a  = '0;
      bus.b  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_inrdy", {31'd0, bus.in_ready}, 32'd1);
      chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_busy",  {31'd0, bus.busy}, 32'd0);
      chk("rst_res",   bus.result, 32'd0);
      chk("rst_dbz",   {31'd0, bus.div_by_zero}, 32'd0);
      rst = 1'b0;

      run("mul7x6",  OP_MUL,    32'd7,          32'd6,          0);
      run("mulhu",   OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  0);
      run("mulh",    OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  0);
      run("mulhsu",  OP_MULHSU, 32'hFFFF_FFFF,  32'd2,          0);
      run("div_m7",  OP_DIV,    32'hFFFF_FFF9,  32'd2,          0);
      run("rem_m7",  OP_REM,    32'hFFFF_FFF9,  32'd2,          0);
      run("divu",    OP_DIVU,   32'd100,        32'd7,          0);
      run("remu",    OP_REMU,   32'd100,        32'd7,          0);
      run("divu_z",  OP_DIVU,   32'd5,          32'd0,          0);
      run("rem_z",   OP_REM,    32'h1234_5678,  32'd0,          0);
      run("div_ovf", OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  0);
      run("rem_ovf", OP_REM,    32'h8000_0000,  32'hFFFF_FFFF,  0);

      // Backpressure with a new request already waiting, then back-to-back accept
      start_op(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678);
      get_result("bp", OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678);
      bus.in_valid = 1'b1;
      bus.op = OP_DIV;
      bus.a  = 32'hFFFF_FF00;
      bus.b  = 32'd9;
      consume("bp", 10);
      start_op(OP_DIV, 32'hFFFF_FF00, 32'd9);
      get_result("b2b", OP_DIV, 32'hFFFF_FF00, 32'd9);
      consume("b2b", 0);

      // Reset at iteration 15 of a divide aborts it
      start_op(OP_DIVU, 32'hFFFF_FFFF, 32'd3);
      repeat (14) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_inrdy", {31'd0, bus.in_ready}, 32'd1);
      chk("abort_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("abort_res",   bus.result, 32'd0);
      chk("abort_busy",  {31'd0, bus.busy}, 32'd0);
      run("post_rst", OP_MUL, 32'd3, 32'd5, 0);

      // Randomized operations with biased corner operands
      for (int i = 0; i < 60; i++) begin
         rop = muldiv_op_t'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: begin ra = $urandom_range(0, 255); rb = $urandom_range(1, 15); end
            3: rb = -($urandom_range(1, 100));
            default: ;
         endcase
         run("rand", rop, ra, rb, $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end
endmodule
